// File: rtl/picorv32_top.sv
// Minimal RV32 subset core (LUI/ADDI/SW) on a Wishbone port with inverted ack/read data.
// Custom opcode 0x27 LUT accumulator is present only when PICORV32_TOP_ESTIMATOR_EN is defined.
module picorv32_top #(
  parameter int N                 = 8,
  parameter int WIDTH_COEFFICIENT = 22,
  parameter int LUT_SIZE          = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:2] adr,
  output logic [31:0] dat,
  output logic [3:0]  sel,
  output logic        we,
  output logic        cyc,
  input  logic [31:0] rdt_n,
  input  logic        ack_n,
  output logic        pcpi_valid_tb,
  output logic [31:0] pcpi_insn_tb,
  output logic [31:0] pcpi_rs1_tb,
  output logic [31:0] pcpi_rs2_tb,
  output logic [5:0]  pcpi_insn_decoded
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_CUSTOM = 7'h27;

  typedef enum logic [2:0] {S_FETCH, S_FWAIT, S_EXEC, S_SWAIT, S_HALT} state_t;

  state_t      state, state_nxt;
  logic        ack;
  logic [31:0] pc, insn, insn_q, rs1_q, rs2_q;
  logic [31:0] regs [32];
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, rs1_val, rs2_val, rd_val, acc_rd, cnt_rd;
  logic        rd_we, halt, store, custom;

  if ((N % LUT_SIZE) != 0 || WIDTH_COEFFICIENT > 32) begin : g_param_check
    $error("picorv32_top: unsupported parameter combination");
  end

  assign ack     = ~ack_n;
  assign opcode  = insn[6:0];
  assign rd      = insn[11:7];
  assign funct3  = insn[14:12];
  assign rs1     = insn[19:15];
  assign rs2     = insn[24:20];
  assign funct7  = insn[31:25];
  assign imm_i   = {{20{insn[31]}}, insn[31:20]};
  assign imm_s   = {{20{insn[31]}}, insn[31:25], insn[11:7]};
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  always_comb begin
    state_nxt = state;
    rd_we     = 1'b0;
    rd_val    = 32'd0;
    halt      = 1'b0;
    store     = 1'b0;
    custom    = 1'b0;
    case (state)
      S_FETCH: state_nxt = S_FWAIT;
      S_FWAIT: if (ack) state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_FETCH;
        case (opcode)
          OP_LUI: begin
            rd_we  = 1'b1;
            rd_val = {insn[31:12], 12'h000};
          end
          OP_IMM: begin
            if (funct3 == 3'b000) begin
              rd_we  = 1'b1;
              rd_val = rs1_val + imm_i;
            end else begin
              halt = 1'b1;
            end
          end
          OP_STORE: begin
            if (funct3 == 3'b010) begin
              store     = 1'b1;
              state_nxt = S_SWAIT;
            end else begin
              halt = 1'b1;
            end
          end
          OP_CUSTOM: begin
            if (funct7 == 7'd0 && funct3 <= 3'd5) begin
              custom = 1'b1;
              if (funct3 == 3'd3) begin
                rd_we  = 1'b1;
                rd_val = acc_rd;
              end else if (funct3 == 3'd4) begin
                rd_we  = 1'b1;
                rd_val = cnt_rd;
              end
            end else begin
              halt = 1'b1;
            end
          end
          default: halt = 1'b1;
        endcase
        if (halt) state_nxt = S_HALT;
      end
      S_SWAIT: if (ack) state_nxt = S_FETCH;
      default: state_nxt = S_HALT;
    endcase
  end

  // Snapshot of the EXEC-cycle values is held until the next EXEC; cleared on halt.
  assign pcpi_valid_tb     = custom;
  assign pcpi_insn_decoded = custom ? (6'b000001 << funct3) : 6'b000000;
  assign pcpi_insn_tb      = (state == S_EXEC) ? insn    : insn_q;
  assign pcpi_rs1_tb       = (state == S_EXEC) ? rs1_val : rs1_q;
  assign pcpi_rs2_tb       = (state == S_EXEC) ? rs2_val : rs2_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S_FETCH;
      pc     <= 32'd0;
      cyc    <= 1'b0;
      we     <= 1'b0;
      sel    <= 4'h0;
      adr    <= 30'd0;
      dat    <= 32'd0;
      insn   <= 32'd0;
      insn_q <= 32'd0;
      rs1_q  <= 32'd0;
      rs2_q  <= 32'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_FETCH: begin
          cyc <= 1'b1;
          we  <= 1'b0;
          sel <= 4'hF;
          adr <= pc[31:2];
        end
        S_FWAIT: begin
          if (ack) begin
            cyc  <= 1'b0;
            insn <= ~rdt_n;
          end
        end
        S_EXEC: begin
          if (halt) begin
            insn_q <= 32'd0;
            rs1_q  <= 32'd0;
            rs2_q  <= 32'd0;
          end else begin
            insn_q <= insn;
            rs1_q  <= rs1_val;
            rs2_q  <= rs2_val;
            pc     <= pc + 32'd4;
          end
          if (store) begin
            cyc <= 1'b1;
            we  <= 1'b1;
            sel <= 4'hF;
            adr <= 30'((rs1_val + imm_s) >> 2);
            dat <= rs2_val;
          end
          if (rd_we && rd != 5'd0) regs[rd] <= rd_val;
        end
        S_SWAIT: begin
          if (ack) begin
            cyc <= 1'b0;
            we  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PICORV32_TOP_ESTIMATOR_EN
  localparam int GROUPS    = N / LUT_SIZE;
  localparam int ENTRIES   = 1 << LUT_SIZE;
  localparam int LUT_DEPTH = GROUPS * ENTRIES;
  localparam int LUT_AW    = $clog2(LUT_DEPTH);

  logic signed [WIDTH_COEFFICIENT-1:0] lut [LUT_DEPTH];
  logic [31:0]       acc, cnt, calc_sum;
  logic [LUT_AW-1:0] lut_idx;

  // Each group of LUT_SIZE rs1 bits picks one signed coefficient from its own bank.
  always_comb begin
    calc_sum = 32'd0;
    lut_idx  = '0;
    for (int g = 0; g < GROUPS; g++) begin
      lut_idx  = LUT_AW'(g * ENTRIES) + LUT_AW'(rs1_val[g*LUT_SIZE +: LUT_SIZE]);
      calc_sum = calc_sum + {{(32-WIDTH_COEFFICIENT){lut[lut_idx][WIDTH_COEFFICIENT-1]}}, lut[lut_idx]};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc <= 32'd0;
      cnt <= 32'd0;
      for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
    end else if (custom) begin
      case (funct3)
        3'd0: begin
          acc <= 32'd0;
          cnt <= 32'd0;
        end
        3'd1: lut[rs1_val[LUT_AW-1:0]] <= rs2_val[WIDTH_COEFFICIENT-1:0];
        3'd2: begin
          acc <= acc + calc_sum;
          cnt <= cnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign acc_rd = acc;
  assign cnt_rd = cnt;
`else
  assign acc_rd = 32'd0;
  assign cnt_rd = 32'd0;
`endif

endmodule

// File: tb/tb_picorv32_top.sv
// Scoreboard bench for picorv32_top: programs memory, predicts stores and custom-op strobes,
// and checks reset, halt and reset-during-bus-cycle behaviour.
module tb_picorv32_top;

  logic        clk, resetn;
  logic [31:2] adr;
  logic [31:0] dat, rdt_n;
  logic [3:0]  sel;
  logic        we, cyc, ack_n;
  logic        pcpi_valid_tb;
  logic [31:0] pcpi_insn_tb, pcpi_rs1_tb, pcpi_rs2_tb;
  logic [5:0]  pcpi_insn_decoded;

  picorv32_top dut (
    .clk(clk), .resetn(resetn), .adr(adr), .dat(dat), .sel(sel), .we(we), .cyc(cyc),
    .rdt_n(rdt_n), .ack_n(ack_n), .pcpi_valid_tb(pcpi_valid_tb), .pcpi_insn_tb(pcpi_insn_tb),
    .pcpi_rs1_tb(pcpi_rs1_tb), .pcpi_rs2_tb(pcpi_rs2_tb), .pcpi_insn_decoded(pcpi_insn_decoded)
  );

  typedef struct packed {logic [29:0] adr; logic [31:0] dat;} wr_t;
  typedef struct packed {logic [31:0] insn; logic [5:0] dec; logic [31:0] rs1; logic [31:0] rs2;} pcpi_t;

  wr_t         exp_wr[$];
  pcpi_t       exp_pcpi[$];
  logic [31:0] mem [512];
  logic [31:0] xr [32];
`ifdef PICORV32_TOP_ESTIMATOR_EN
  logic signed [21:0] mlut [16];
  logic [31:0]        macc, mcnt;
`endif
  int n_cmp = 0, n_err = 0, wp, exp_pc_word;
  bit resp_en, inject_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 512; i++) mem[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) xr[i] = 32'd0;
`ifdef PICORV32_TOP_ESTIMATOR_EN
    for (int i = 0; i < 16; i++) mlut[i] = '0;
    macc = 32'd0;
    mcnt = 32'd0;
`endif
    wp = 0;
  endtask

  task automatic emit(input logic [31:0] w);
    mem[wp] = w;
    wp++;
  endtask

  task automatic t_lui(input int rd, input logic [19:0] imm);
    emit({imm, rd[4:0], 7'b0110111});
    if (rd != 0) xr[rd] = {imm, 12'h000};
  endtask

  task automatic t_addi(input int rd, input int rs1, input int imm);
    logic [11:0] i12;
    i12 = imm[11:0];
    emit({i12, rs1[4:0], 3'b000, rd[4:0], 7'b0010011});
    if (rd != 0) xr[rd] = xr[rs1] + {{20{i12[11]}}, i12};
  endtask

  task automatic t_sw(input int rs2, input int rs1, input int imm);
    logic [11:0] i12;
    logic [31:0] ea;
    wr_t e;
    i12 = imm[11:0];
    emit({i12[11:5], rs2[4:0], rs1[4:0], 3'b010, i12[4:0], 7'b0100011});
    ea = xr[rs1] + {{20{i12[11]}}, i12};
    e.adr = ea[31:2];
    e.dat = xr[rs2];
    exp_wr.push_back(e);
  endtask

  task automatic t_cust(input int f3, input int rd, input int rs1, input int rs2);
    logic [31:0] w;
    pcpi_t p;
`ifdef PICORV32_TOP_ESTIMATOR_EN
    logic [31:0] a, sum;
`endif
    w = {7'b0, rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h27};
    emit(w);
    p.insn = w;
    p.dec  = 6'(1 << f3);
    p.rs1  = xr[rs1];
    p.rs2  = xr[rs2];
    exp_pcpi.push_back(p);
`ifdef PICORV32_TOP_ESTIMATOR_EN
    a = xr[rs1];
    case (f3)
      0: begin macc = 32'd0; mcnt = 32'd0; end
      1: mlut[a[3:0]] = xr[rs2][21:0];
      2: begin
        sum = 32'd0;
        for (int g = 0; g < 4; g++) sum = sum + 32'(int'(mlut[4*g + int'(a[2*g +: 2])]));
        macc = macc + sum;
        mcnt = mcnt + 32'd1;
      end
      3: if (rd != 0) xr[rd] = macc;
      4: if (rd != 0) xr[rd] = mcnt;
      default: ;
    endcase
`else
    if ((f3 == 3 || f3 == 4) && rd != 0) xr[rd] = 32'd0;
`endif
  endtask

  // Wishbone slave: random 0..2 wait states, inverted ack and read data.
  initial begin : responder
    int lat;
    bit started;
    logic [29:0] a0;
    ack_n = 1'b1;
    rdt_n = 32'hFFFF_FFFF;
    lat = 0;
    started = 1'b0;
    a0 = '0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        started = 1'b0;
        ack_n = !inject_ack;
      end else if (!ack_n || !cyc) begin
        ack_n = 1'b1;
        started = 1'b0;
      end else begin
        if (!started) begin
          started = 1'b1;
          lat = $urandom_range(0, 2);
          a0 = adr;
        end
        if (lat == 0) begin
          check("bus_hold_adr", {2'b0, adr}, {2'b0, a0});
          check("bus_sel", {28'd0, sel}, 32'hF);
          if (we) begin
            check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
              wr_t e;
              e = exp_wr.pop_front();
              check("wr_adr", {2'b0, adr}, {2'b0, e.adr});
              check("wr_dat", dat, e.dat);
            end
          end else begin
            check("fetch_adr", {2'b0, adr}, 32'(exp_pc_word));
            exp_pc_word++;
            rdt_n = ~mem[adr[10:2]];
          end
          ack_n = 1'b0;
        end else begin
          lat--;
        end
      end
    end
  end

  initial begin : pcpi_monitor
    forever begin
      @(negedge clk);
      if (pcpi_valid_tb) begin
        check("pcpi_expected", 32'(exp_pcpi.size() != 0), 32'd1);
        if (exp_pcpi.size() != 0) begin
          pcpi_t p;
          p = exp_pcpi.pop_front();
          check("pcpi_insn", pcpi_insn_tb, p.insn);
          check("pcpi_dec", {26'd0, pcpi_insn_decoded}, {26'd0, p.dec});
          check("pcpi_rs1", pcpi_rs1_tb, p.rs1);
          check("pcpi_rs2", pcpi_rs2_tb, p.rs2);
        end
      end else begin
        check("pcpi_dec_idle", {26'd0, pcpi_insn_decoded}, 32'd0);
      end
    end
  end

  task automatic drain(input string tag);
    int i;
    for (i = 0; i < 20000 && (exp_wr.size() != 0 || exp_pcpi.size() != 0); i++) @(negedge clk);
    check({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    check({tag, "_pcpi_left"}, 32'(exp_pcpi.size()), 32'd0);
  endtask

  task automatic check_halt(input string tag, input int cycles);
    bit seen_cyc, seen_pcpi;
    seen_cyc = 1'b0;
    seen_pcpi = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (cyc) seen_cyc = 1'b1;
      if (pcpi_valid_tb || pcpi_insn_tb != 0 || pcpi_rs1_tb != 0 || pcpi_rs2_tb != 0) seen_pcpi = 1'b1;
    end
    check({tag, "_cyc"}, 32'(seen_cyc), 32'd0);
    check({tag, "_pcpi"}, 32'(seen_pcpi), 32'd0);
  endtask

  initial begin : main
    resetn = 1'b0;
    resp_en = 1'b1;
    inject_ack = 1'b0;
    exp_pc_word = 0;
    clear_model();

    // Straight-line program: base ISA, x0, LUT load, CALC/RD/CNT, then wrap past 0x7FFFFFFF.
    t_lui(1, 20'h10000);
    t_addi(2, 0, 12'h0AD);
    t_sw(2, 1, 4);
    t_cust(2, 3, 1, 2);
    t_addi(0, 0, 5);
    t_sw(0, 0, 8);
    t_addi(10, 0, 0);  t_addi(11, 0, 5);  t_cust(1, 0, 10, 11);
    t_addi(10, 0, 4);  t_addi(11, 0, -3); t_cust(1, 0, 10, 11);
    t_addi(10, 0, 8);  t_lui(11, 20'h00200); t_addi(11, 11, -1); t_cust(1, 0, 10, 11);
    t_addi(10, 0, 12); t_addi(11, 0, 1);  t_cust(1, 0, 10, 11);
    t_cust(0, 0, 0, 0);
    t_cust(2, 0, 0, 0);
    t_cust(3, 12, 0, 0);
    t_cust(4, 13, 0, 0);
    t_sw(12, 0, 0);
    t_sw(13, 0, 4);
    t_lui(11, 20'h00200); t_addi(11, 11, -1);
    for (int i = 1; i < 16; i += 4) begin
      t_addi(10, 0, i);
      t_cust(1, 0, 10, 11);
    end
    t_addi(11, 0, 1023); t_addi(10, 0, 2); t_cust(1, 0, 10, 11);
    t_addi(11, 0, 1);    t_addi(10, 0, 3); t_cust(1, 0, 10, 11);
    t_addi(20, 0, 12'h055); t_addi(21, 0, 12'h0AA); t_addi(22, 0, 12'h0FF);
    t_cust(0, 0, 0, 0);
    for (int i = 0; i < 256; i++) t_cust(2, 0, 20, 0);
    t_cust(2, 0, 21, 0);
    t_cust(3, 12, 0, 0);
    t_sw(12, 0, 12);
    t_cust(2, 0, 22, 0);
    t_cust(3, 12, 0, 0);
    t_cust(4, 13, 0, 0);
    t_sw(12, 0, 16);
    t_sw(13, 0, 20);
    t_cust(5, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_sel", {28'd0, sel}, 32'd0);
    check("rst_adr", {2'b0, adr}, 32'd0);
    check("rst_dat", dat, 32'd0);
    check("rst_valid", 32'(pcpi_valid_tb), 32'd0);
    check("rst_insn", pcpi_insn_tb, 32'd0);
    check("rst_rs1", pcpi_rs1_tb, 32'd0);
    check("rst_rs2", pcpi_rs2_tb, 32'd0);

    resetn = 1'b1;
    drain("prog");
    check_halt("halt", 100);

    // Second run: reset lands on an open fetch with an ack pending, then an illegal funct3 halts.
    resetn = 1'b0;
    resp_en = 1'b0;
    clear_model();
    t_cust(5, 0, 0, 0);
    emit({7'b0, 5'd0, 5'd0, 3'd6, 5'd0, 7'h27});
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 20 && !cyc; i++) @(negedge clk);
    check("open_fetch_cyc", 32'(cyc), 32'd1);
    check("open_fetch_adr", {2'b0, adr}, 32'd0);
    repeat (3) @(negedge clk);
    check("fwait_hold_cyc", 32'(cyc), 32'd1);
    @(posedge clk);
    #1 inject_ack = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_drop_cyc", 32'(cyc), 32'd0);
    inject_ack = 1'b0;
    @(negedge clk);
    exp_pc_word = 0;
    resp_en = 1'b1;
    resetn = 1'b1;
    drain("refetch");
    check_halt("illegal_halt", 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/picorv32_top.md
PICORV32_TOP -- requirements
Module: picorv32_top

Interface
REQ-001 SHALL have parameter N, default 8: control-bit inputs per CALC.
REQ-002 SHALL have parameter WIDTH_COEFFICIENT, default 22: signed LUT coefficient width.
REQ-003 SHALL have parameter LUT_SIZE, default 2: control bits per LUT group; groups = N/LUT_SIZE = 4, entries per group = 2^LUT_SIZE = 4.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port adr, output, [31:2]: Wishbone word address.
REQ-007 SHALL have port dat, output, 32 bits: Wishbone write data.
REQ-008 SHALL have port sel, output, 4 bits: byte enables.
REQ-009 SHALL have port we, output, 1 bit: write enable.
REQ-010 SHALL have port cyc, output, 1 bit: bus cycle active.
REQ-011 SHALL have port rdt_n, input, 32 bits: inverted read data; true data = ~rdt_n.
REQ-012 SHALL have port ack_n, input, 1 bit: inverted acknowledge; ack = ~ack_n.
REQ-013 SHALL have port pcpi_valid_tb, output, 1 bit: custom instruction issue strobe.
REQ-014 SHALL have ports pcpi_insn_tb, pcpi_rs1_tb and pcpi_rs2_tb, outputs, 32 bits each: current instruction, rs1 value and rs2 value.
REQ-015 SHALL have port pcpi_insn_decoded, output, 6 bits: one-hot custom-op decode.

Function
REQ-016 SHALL run FSM FETCH->FWAIT->EXEC->{FETCH | SWAIT->FETCH | HALT}; pc starts at 0 and increments by 4 after each non-halting instruction.
REQ-017 Bus: SHALL hold cyc/adr/we/sel/dat stable until ack sampled high, latch ~rdt_n on the ack cycle, drop cyc next cycle, and keep cyc low at least one cycle between accesses.
REQ-018 Fetch: cyc=1, we=0, sel=4'hF, adr=pc[31:2].
REQ-019 SHALL support LUI, ADDI and SW (word only: sel=4'hF, address bits [1:0] ignored, dat=rs2); 32x32 register file; x0 reads zero and ignores writes.
REQ-020 Custom ops: opcode 7'h27, funct7=0, funct3 0..5; pcpi_insn_decoded[funct3]=1 and pcpi_valid_tb=1 for exactly the EXEC cycle, otherwise both are 0.
REQ-021 pcpi_insn_tb/rs1_tb/rs2_tb SHALL update in EXEC for every instruction and hold until the next EXEC.
REQ-022 funct3=0 CLR: acc=0, cnt=0. funct3=1 LUTW: lut[rs1[3:0]]=rs2[21:0].
REQ-023 funct3=2 CALC: acc += sum over g=0..3 of sext32(lut[4g + rs1[2g+1:2g]]); cnt += 1; modulo 2^32.
REQ-024 funct3=3 RD: rd=acc. funct3=4 CNT: rd=cnt. funct3=5: no-op.
REQ-025 Any other opcode, funct7≠0, or funct3 6/7 SHALL enter HALT: cyc=0 and pcpi outputs 0 until reset.

Reset
REQ-026 While resetn=0 at a clock edge: pc=0, state=FETCH, cyc=we=0, sel=0, adr=0, dat=0, pcpi_*=0, registers/acc/cnt/LUT=0.
REQ-027 Reset during a bus cycle SHALL drop cyc at that edge; a pending ack is ignored.

Configuration
REQ-028 With PICORV32_TOP_ESTIMATOR_EN defined, REQ-022..024 are implemented.
REQ-029 Without PICORV32_TOP_ESTIMATOR_EN, custom ops still decode and strobe, acc/cnt/LUT are absent, RD/CNT write 0, CLR/LUTW/CALC are no-ops.

Verification
REQ-030 Memory words 0x100000B7, 0x0AD00113, 0x0020A223 -> write cycle with adr=30'h0400_0001, dat=0x000000AD, we=1, sel=4'hF.
REQ-031 Custom op 0x0020A1A7 -> pcpi_valid_tb=1 and pcpi_insn_decoded=6'b000100 for one cycle; pcpi_insn_tb=0x0020A1A7.
REQ-032 LUTW sequence: lut[0]=5, lut[4]=-3, lut[8]=0x1FFFFF, lut[12]=1; then CALC with rs1=0, then RD -> acc=0x00200002; CNT -> 1.
REQ-033 acc=0x7FFFFFFF, then CALC adding 1 -> acc=0x80000000, no saturation.
REQ-034 resetn=0 while cyc=1 and ack pending -> cyc=0 next edge; refetch from pc=0 after release.
REQ-035 Word 0xFFFFFFFF fetched -> HALT; cyc stays 0 for 100 cycles.
